// File: rtl/push_pull_fifo.sv
// push_pull_fifo: register-array FIFO with four-phase req/ack handshakes on both sides
//
// A writer pushes words with put_req/put_ack and a reader pulls words with
// get_req/get_ack. Each request is served at most once: its ack rises one edge
// after acceptance and stays high until the requester drops its req.
//
// Optional feature macro: PPFIFO_STATUS_EN
//   defined   -> full/empty/count ports exist, plus the "put only when !full" assertion
//   undefined -> those ports and the assertion are absent; handshakes are unchanged
//
// Ports:
//   clock      in   single clock, all state changes on posedge
//   reset_n    in   asynchronous active-low reset
//   clear      in   synchronous clear; empties the FIFO and drops both acks
//   put_req    in   writer request; put_value valid while high
//   put_ack    out  write accepted; held until put_req drops
//   put_value  in   word to enqueue
//   get_req    in   reader request
//   get_ack    out  read complete; get_value valid while high
//   get_value  out  dequeued word; held until the next accepted get
//   full       out  [PPFIFO_STATUS_EN] count == depth
//   empty      out  [PPFIFO_STATUS_EN] count == 0
//   count      out  [PPFIFO_STATUS_EN] words stored, 0..depth
module push_pull_fifo #(
    parameter int FIFO_WORD_SIZE    = 1,
    parameter int FIFO_POINTER_BITS = 2
) (
    input  logic                         clock,
    input  logic                         reset_n,
    input  logic                         clear,
    input  logic                         put_req,
    output logic                         put_ack,
    input  logic [FIFO_WORD_SIZE-1:0]    put_value,
    input  logic                         get_req,
    output logic                         get_ack,
    output logic [FIFO_WORD_SIZE-1:0]    get_value
`ifdef PPFIFO_STATUS_EN
    ,
    output logic                         full,
    output logic                         empty,
    output logic [FIFO_POINTER_BITS:0]   count
`endif
);
    localparam logic [FIFO_POINTER_BITS:0] DEPTH = {1'b1, {FIFO_POINTER_BITS{1'b0}}};

    logic [FIFO_WORD_SIZE-1:0]    mem [0:(1<<FIFO_POINTER_BITS)-1];
    logic [FIFO_POINTER_BITS-1:0] wr_ptr;
    logic [FIFO_POINTER_BITS-1:0] rd_ptr;
    logic [FIFO_POINTER_BITS:0]   level;
    logic                         put_acc;
    logic                         get_acc;

    // Acceptance is judged on the pre-edge level, so a put at full is refused
    // even when a get completes on the same edge, and a get on empty never sees
    // a word written that same edge.
    always_comb begin
        put_acc = put_req && !put_ack && (level != DEPTH);
        get_acc = get_req && !get_ack && (level != '0);
    end

    // Storage has no reset; only words behind valid pointers are ever read.
    always_ff @(posedge clock) begin
        if (put_acc && !clear)
            mem[wr_ptr] <= put_value;
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            put_ack   <= 1'b0;
            get_ack   <= 1'b0;
            get_value <= '0;
        end else if (clear) begin
            wr_ptr    <= '0;
            rd_ptr    <= '0;
            level     <= '0;
            put_ack   <= 1'b0;
            get_ack   <= 1'b0;
            get_value <= '0;
        end else begin
            if (put_acc)
                wr_ptr <= wr_ptr + FIFO_POINTER_BITS'(1);
            if (get_acc) begin
                rd_ptr    <= rd_ptr + FIFO_POINTER_BITS'(1);
                get_value <= mem[rd_ptr];
            end
            level   <= level + (FIFO_POINTER_BITS+1)'(put_acc) - (FIFO_POINTER_BITS+1)'(get_acc);
            // An ack rises on acceptance and then tracks its req until the req drops.
            put_ack <= put_req && (put_ack || put_acc);
            get_ack <= get_req && (get_ack || get_acc);
        end
    end

`ifdef PPFIFO_STATUS_EN
    always_comb begin
        full  = (level == DEPTH);
        empty = (level == '0);
        count = level;
    end

    put_only_when_not_full: assert property (
        @(posedge clock) disable iff (!reset_n) put_acc |-> !full
    );
`endif

endmodule

// File: tb/tb_push_pull_fifo.sv
// tb_push_pull_fifo: directed self-checking bench for push_pull_fifo (8-bit words, depth 4)
module tb_push_pull_fifo;
    logic       clock = 1'b0;
    logic       reset_n;
    logic       clear;
    logic       put_req;
    logic       put_ack;
    logic [7:0] put_value;
    logic       get_req;
    logic       get_ack;
    logic [7:0] get_value;
`ifdef PPFIFO_STATUS_EN
    logic       full;
    logic       empty;
    logic [2:0] count;
`endif

    int checks = 0;
    int errors = 0;

    push_pull_fifo #(.FIFO_WORD_SIZE(8), .FIFO_POINTER_BITS(2)) dut (
        .clock(clock),
        .reset_n(reset_n),
        .clear(clear),
        .put_req(put_req),
        .put_ack(put_ack),
        .put_value(put_value),
        .get_req(get_req),
        .get_ack(get_ack),
        .get_value(get_value)
`ifdef PPFIFO_STATUS_EN
        ,
        .full(full),
        .empty(empty),
        .count(count)
`endif
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       clr;
        logic       preq;
        logic [7:0] pval;
        logic       greq;
        logic       e_pack;
        logic       e_gack;
        logic [7:0] e_gval;
        logic [2:0] e_cnt;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(logic clr, logic preq, logic [7:0] pval, logic greq,
                                logic e_pack, logic e_gack, logic [7:0] e_gval, logic [2:0] e_cnt);
        vec_t v;
        v.clr = clr; v.preq = preq; v.pval = pval; v.greq = greq;
        v.e_pack = e_pack; v.e_gack = e_gack; v.e_gval = e_gval; v.e_cnt = e_cnt;
        return v;
    endfunction

    task automatic check(string name, logic [31:0] act, logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clock);
        @(negedge clock);
    endtask

    task automatic put_word(logic [7:0] v);
        int n;
        n = 0;
        put_req = 1'b1;
        put_value = v;
        do begin
            tick();
            n++;
        end while (!put_ack && n < 20);
        check("put_ack_rise", put_ack, 1);
        put_req = 1'b0;
        tick();
        check("put_ack_fall", put_ack, 0);
    endtask

    task automatic get_word(logic [7:0] exp);
        int n;
        n = 0;
        get_req = 1'b1;
        do begin
            tick();
            n++;
        end while (!get_ack && n < 20);
        check("get_ack_rise", get_ack, 1);
        check("get_value", get_value, exp);
        get_req = 1'b0;
        tick();
        check("get_ack_fall", get_ack, 0);
        check("get_value_hold", get_value, exp);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] e;

        // 1 clear, 2 four puts (req held 2 cycles each) then four gets, then a get on empty
        vecs.push_back(mk(1, 0, 8'h00, 0, 0, 0, 8'h00, 0));
        vecs.push_back(mk(0, 1, 8'h11, 0, 1, 0, 8'h00, 1));
        vecs.push_back(mk(0, 1, 8'h11, 0, 1, 0, 8'h00, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 1));
        vecs.push_back(mk(0, 1, 8'h22, 0, 1, 0, 8'h00, 2));
        vecs.push_back(mk(0, 1, 8'h22, 0, 1, 0, 8'h00, 2));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 2));
        vecs.push_back(mk(0, 1, 8'h33, 0, 1, 0, 8'h00, 3));
        vecs.push_back(mk(0, 1, 8'h33, 0, 1, 0, 8'h00, 3));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 3));
        vecs.push_back(mk(0, 1, 8'h44, 0, 1, 0, 8'h00, 4));
        vecs.push_back(mk(0, 1, 8'h44, 0, 1, 0, 8'h00, 4));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h00, 4));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'h11, 3));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'h11, 3));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h11, 3));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'h22, 2));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'h22, 2));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h22, 2));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'h33, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'h33, 1));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h33, 1));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'h44, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 1, 8'h44, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h44, 0));
        vecs.push_back(mk(0, 0, 8'h00, 1, 0, 0, 8'h44, 0));
        vecs.push_back(mk(0, 0, 8'h00, 0, 0, 0, 8'h44, 0));

        reset_n = 1'b0;
        clear = 1'b0;
        put_req = 1'b0;
        put_value = '0;
        get_req = 1'b0;
        tick();
        tick();
        check("reset_put_ack", put_ack, 0);
        check("reset_get_ack", get_ack, 0);
        check("reset_get_value", get_value, 0);
        reset_n = 1'b1;
        tick();

        foreach (vecs[i]) begin
            clear = vecs[i].clr;
            put_req = vecs[i].preq;
            put_value = vecs[i].pval;
            get_req = vecs[i].greq;
            tick();
            check($sformatf("vec%0d_put_ack", i), put_ack, vecs[i].e_pack);
            check($sformatf("vec%0d_get_ack", i), get_ack, vecs[i].e_gack);
            check($sformatf("vec%0d_get_value", i), get_value, vecs[i].e_gval);
`ifdef PPFIFO_STATUS_EN
            check($sformatf("vec%0d_count", i), count, vecs[i].e_cnt);
            check($sformatf("vec%0d_empty", i), empty, vecs[i].e_cnt == 0);
            check($sformatf("vec%0d_full", i), full, vecs[i].e_cnt == 4);
`endif
        end
        clear = 1'b0;

        // 3 fifth put waits at full, accepted the edge after a get frees a slot
        for (int i = 1; i <= 4; i++) put_word(8'(i));
        put_req = 1'b1;
        put_value = 8'h05;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("full_put_refused", put_ack, 0);
        end
        get_req = 1'b1;
        tick();
        check("full_get_ack", get_ack, 1);
        check("full_get_value", get_value, 8'h01);
        check("full_put_still_refused", put_ack, 0);
        tick();
        check("full_put_late_ack", put_ack, 1);
        put_req = 1'b0;
        get_req = 1'b0;
        tick();
        for (int i = 2; i <= 5; i++) get_word(8'(i));

        // 4 get waits on empty; served the edge after the write, not the same edge
        get_req = 1'b1;
        for (int i = 0; i < 10; i++) begin
            tick();
            check("empty_get_wait", get_ack, 0);
        end
        put_req = 1'b1;
        put_value = 8'hA5;
        tick();
        check("empty_put_ack", put_ack, 1);
        check("no_write_through", get_ack, 0);
        tick();
        check("empty_get_served", get_ack, 1);
        check("empty_get_value", get_value, 8'hA5);
        put_req = 1'b0;
        get_req = 1'b0;
        tick();

        // 5 simultaneous put+get at count 2, then 12 words through for pointer wrap
        put_word(8'h50);
        put_word(8'h51);
        put_req = 1'b1;
        put_value = 8'h52;
        get_req = 1'b1;
        tick();
        check("both_put_ack", put_ack, 1);
        check("both_get_ack", get_ack, 1);
        check("both_get_value", get_value, 8'h50);
`ifdef PPFIFO_STATUS_EN
        check("both_count", count, 2);
`endif
        put_req = 1'b0;
        get_req = 1'b0;
        tick();
        q = '{8'h51, 8'h52};
        for (int i = 0; i < 12; i++) begin
            put_word(8'(8'h60 + i));
            q.push_back(8'(8'h60 + i));
            e = q.pop_front();
            get_word(e);
        end
        while (q.size() > 0) begin
            e = q.pop_front();
            get_word(e);
        end

        // 6 clear with 3 words stored and a put pending: nothing kept, put dropped
        put_word(8'h70);
        put_word(8'h71);
        put_word(8'h72);
        put_req = 1'b1;
        put_value = 8'h7F;
        clear = 1'b1;
        tick();
        check("clear_put_ack", put_ack, 0);
        check("clear_get_ack", get_ack, 0);
        check("clear_get_value", get_value, 0);
`ifdef PPFIFO_STATUS_EN
        check("clear_empty", empty, 1);
`endif
        clear = 1'b0;
        put_req = 1'b0;
        get_req = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("clear_get_wait", get_ack, 0);
        end
        put_req = 1'b1;
        put_value = 8'h99;
        tick();
        check("post_clear_put_ack", put_ack, 1);
        check("post_clear_no_get", get_ack, 0);
        tick();
        check("post_clear_get_ack", get_ack, 1);
        check("post_clear_get_value", get_value, 8'h99);
        put_req = 1'b0;
        get_req = 1'b0;
        tick();

        // async reset mid-handshake drops the ack without waiting for an edge
        put_req = 1'b1;
        put_value = 8'h33;
        tick();
        check("pre_reset_put_ack", put_ack, 1);
        #2 reset_n = 1'b0;
        #1;
        check("async_reset_put_ack", put_ack, 0);
        check("async_reset_get_value", get_value, 0);
        put_req = 1'b0;
        tick();
        reset_n = 1'b1;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
